// File: rtl/cordic_iter.sv
// Iterative CORDIC: one micro-rotation per clock; mode 0 rotates z to 0, mode 1 drives y to 0.
// Latency start->done ITERS+1 cycles; a start while busy or during done is dropped, not queued.
module cordic_iter #(
  parameter int WIDTH = 32,
  parameter int ITERS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             ovf
);

  localparam int XW = WIDTH + 2;
  localparam logic [4:0] LAST = 5'(ITERS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic signed [XW-1:0]    x_r, y_r;
  logic signed [WIDTH-1:0] z_r;
  logic                    mode_r;
  logic [4:0]              i_r;

  // atan(2^-i) in Q2.30 radians, rounded to nearest
  function automatic logic signed [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_rom = 32'h3243F6A9;
      5'd1:  atan_rom = 32'h1DAC6705;
      5'd2:  atan_rom = 32'h0FADBAFD;
      5'd3:  atan_rom = 32'h07F56EA7;
      5'd4:  atan_rom = 32'h03FEAB77;
      5'd5:  atan_rom = 32'h01FFD55C;
      5'd6:  atan_rom = 32'h00FFFAAB;
      5'd7:  atan_rom = 32'h007FFF55;
      5'd8:  atan_rom = 32'h003FFFEB;
      5'd9:  atan_rom = 32'h001FFFFD;
      5'd10: atan_rom = 32'h00100000;
      5'd11: atan_rom = 32'h00080000;
      5'd12: atan_rom = 32'h00040000;
      5'd13: atan_rom = 32'h00020000;
      5'd14: atan_rom = 32'h00010000;
      5'd15: atan_rom = 32'h00008000;
      5'd16: atan_rom = 32'h00004000;
      5'd17: atan_rom = 32'h00002000;
      5'd18: atan_rom = 32'h00001000;
      5'd19: atan_rom = 32'h00000800;
      5'd20: atan_rom = 32'h00000400;
      5'd21: atan_rom = 32'h00000200;
      5'd22: atan_rom = 32'h00000100;
      5'd23: atan_rom = 32'h00000080;
      5'd24: atan_rom = 32'h00000040;
      5'd25: atan_rom = 32'h00000020;
      5'd26: atan_rom = 32'h00000010;
      5'd27: atan_rom = 32'h00000008;
      5'd28: atan_rom = 32'h00000004;
      5'd29: atan_rom = 32'h00000002;
      5'd30: atan_rom = 32'h00000001;
      default: atan_rom = 32'h00000000;
    endcase
  endfunction

  logic signed [31:0]      atan_full;
  logic signed [WIDTH-1:0] atan_i;
  logic                    d_pos;
  logic signed [XW-1:0]    x_sh, y_sh, x_nxt, y_nxt;
  logic signed [WIDTH-1:0] z_nxt;
  logic [2:0]              x_top, y_top;
  logic                    x_clip, y_clip;
  logic [WIDTH-1:0]        x_sat, y_sat;

  assign atan_full = atan_rom(i_r);
  assign atan_i    = WIDTH'(atan_full >>> (32 - WIDTH));

  assign d_pos = mode_r ? y_r[XW-1] : ~z_r[WIDTH-1];
  assign x_sh  = x_r >>> i_r;
  assign y_sh  = y_r >>> i_r;
  assign x_nxt = d_pos ? (x_r - y_sh) : (x_r + y_sh);
  assign y_nxt = d_pos ? (y_r + x_sh) : (y_r - x_sh);
  assign z_nxt = d_pos ? (z_r - atan_i) : (z_r + atan_i);

  // The two guard bits must match the WIDTH sign bit, otherwise clamp.
  assign x_top  = x_r[XW-1:WIDTH-1];
  assign y_top  = y_r[XW-1:WIDTH-1];
  assign x_clip = (x_top != 3'b000) && (x_top != 3'b111);
  assign y_clip = (y_top != 3'b000) && (y_top != 3'b111);
  assign x_sat  = !x_clip ? x_r[WIDTH-1:0] :
                  x_r[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign y_sat  = !y_clip ? y_r[WIDTH-1:0] :
                  y_r[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
      i_r    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_r    <= {{2{x_in[WIDTH-1]}}, x_in};
            y_r    <= {{2{y_in[WIDTH-1]}}, y_in};
            z_r    <= z_in;
            mode_r <= mode;
            i_r    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // ITERS micro-rotations, then one cycle to saturate and publish
          if (i_r == LAST) begin
            x_out <= x_sat;
            y_out <= y_sat;
            z_out <= z_r;
            ovf   <= x_clip | y_clip;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            x_r <= x_nxt;
            y_r <= y_nxt;
            z_r <= z_nxt;
            i_r <= i_r + 5'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Randomized scoreboard bench for cordic_iter at 32/16 and 16/8 configurations.
module tb_cordic_iter;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int W2 = 16;
  localparam int N2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, mode, busy, done, ovf;
  logic [W-1:0]  x_in, y_in, z_in, x_out, y_out, z_out;
  logic          s_start, s_mode, s_busy, s_done, s_ovf;
  logic [W2-1:0] s_x_in, s_y_in, s_z_in, s_x_out, s_y_out, s_z_out;

  cordic_iter #(.WIDTH(W), .ITERS(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .ovf(ovf));

  cordic_iter #(.WIDTH(W2), .ITERS(N2)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .mode(s_mode),
    .x_in(s_x_in), .y_in(s_y_in), .z_in(s_z_in), .busy(s_busy), .done(s_done),
    .x_out(s_x_out), .y_out(s_y_out), .z_out(s_z_out), .ovf(s_ovf));

  typedef struct {
    longint x;
    longint y;
    longint z;
    bit     ovf;
    int     t0;
  } exp_t;

  exp_t sb[$];
  exp_t sb16[$];
  exp_t me, me16;
  int   cyc = 0;
  int   n_vec = 0, n_err = 0;
  real  k32, k16;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx(input int w, input logic [31:0] v);
    longint t;
    t = longint'(v);
    t = t <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic longint wrapw(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  // Reference: the CORDIC recurrence on wide integers with an atan table built from $atan.
  function automatic exp_t ref_model(input int w, input int n, input bit m,
                                     input longint x0, input longint y0, input longint z0);
    exp_t   e;
    longint x, y, z, xn, at, maxv, minv;
    int     d;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < n; i++) begin
      at = longint'($rtoi($atan(2.0 ** (-i)) * 1073741824.0 + 0.5)) >>> (32 - w);
      d  = m ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
      xn = x - d * (y >>> i);
      y  = y + d * (x >>> i);
      x  = xn;
      z  = wrapw(z - d * at, w);
    end
    maxv  = (longint'(1) <<< (w - 1)) - 1;
    minv  = -(longint'(1) <<< (w - 1));
    e.ovf = 1'b0;
    if (x > maxv) begin x = maxv; e.ovf = 1'b1; end
    else if (x < minv) begin x = minv; e.ovf = 1'b1; end
    if (y > maxv) begin y = maxv; e.ovf = 1'b1; end
    else if (y < minv) begin y = minv; e.ovf = 1'b1; end
    e.x = x; e.y = y; e.z = z; e.t0 = 0;
    return e;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_tol(input string nm, input longint act, input longint exp, input longint tol);
    longint diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    n_vec++;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  // Monitors: pop the oldest expectation whenever a done pulse appears
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        me = sb.pop_front();
        check("x_out", sx(W, x_out), me.x);
        check("y_out", sx(W, y_out), me.y);
        check("z_out", sx(W, z_out), me.z);
        check("ovf", longint'(ovf), longint'(me.ovf));
        check("latency", longint'(cyc - me.t0), N + 1);
        check("busy_at_done", longint'(busy), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (s_done) begin
      if (sb16.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done16: done=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        me16 = sb16.pop_front();
        check("x_out16", sx(W2, {16'h0, s_x_out}), me16.x);
        check("y_out16", sx(W2, {16'h0, s_y_out}), me16.y);
        check("z_out16", sx(W2, {16'h0, s_z_out}), me16.z);
        check("ovf16", longint'(s_ovf), longint'(me16.ovf));
        check("latency16", longint'(cyc - me16.t0), N2 + 1);
      end
    end
  end

  task automatic issue(input bit m, input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi);
    exp_t e;
    e = ref_model(W, N, m, sx(W, xi), sx(W, yi), sx(W, zi));
    @(negedge clk);
    start = 1'b1; mode = m; x_in = xi; y_in = yi; z_in = zi;
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); x_in = $urandom; y_in = $urandom; z_in = $urandom;
    e.t0 = cyc;
    sb.push_back(e);
  endtask

  task automatic issue16(input bit m, input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi);
    exp_t e;
    e = ref_model(W2, N2, m, sx(W2, xi), sx(W2, yi), sx(W2, zi));
    @(negedge clk);
    s_start = 1'b1; s_mode = m; s_x_in = xi[15:0]; s_y_in = yi[15:0]; s_z_in = zi[15:0];
    @(negedge clk);
    s_start = 1'b0; s_x_in = 16'($urandom); s_y_in = 16'($urandom); s_z_in = 16'($urandom);
    e.t0 = cyc;
    sb16.push_back(e);
  endtask

  task automatic wait_done(input bit which);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (which ? s_done : done) return;
    end
    n_vec++; n_err++;
    $display("FAIL done_timeout: no done within 64 cycles (dut %0d)", which);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra, rb, rc;
  bit          rm;
  int          t0h, k, bcnt, dcnt;

  initial begin
    k32 = 1.0; k16 = 1.0;
    for (int i = 0; i < N; i++)  k32 = k32 * $sqrt(1.0 + 2.0 ** (-2 * i));
    for (int i = 0; i < N2; i++) k16 = k16 * $sqrt(1.0 + 2.0 ** (-2 * i));

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    s_start = 1'b0; s_mode = 1'b0; s_x_in = '0; s_y_in = '0; s_z_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_x", longint'(x_out), 0);
    check("rst_y", longint'(y_out), 0);
    check("rst_z", longint'(z_out), 0);
    reset_n = 1'b1;

    // cos/sin(0)
    issue(1'b0, 32'h4000_0000, 32'h0, 32'h0);
    wait_done(1'b0);
    check_tol("rot0_x", sx(W, x_out), longint'($rtoi(k32 * 1073741824.0)), 64);
    check_tol("rot0_y", sx(W, y_out), 0, 32'h20000);
    check_tol("rot0_z", sx(W, z_out), 0, 32'h10000);

    // rotate by pi/2
    issue(1'b0, 32'h4000_0000, 32'h0, 32'h6487_ED51);
    wait_done(1'b0);
    check_tol("rot90_x", sx(W, x_out), 0, 32'h20000);
    check_tol("rot90_y", sx(W, y_out), longint'($rtoi(k32 * 1073741824.0)), 64);

    // vectoring (0.5, 0.5)
    issue(1'b1, 32'h2000_0000, 32'h2000_0000, 32'h0);
    wait_done(1'b0);
    check_tol("vec_x", sx(W, x_out), longint'($rtoi(k32 * 0.5 * $sqrt(2.0) * 1073741824.0)), 64);
    check_tol("vec_y", sx(W, y_out), 0, 32'h20000);
    check_tol("vec_z", sx(W, z_out), longint'($rtoi(0.25 * 3.14159265358979 * 1073741824.0)), 32'h10000);

    // vectoring (1.0, 1.0) saturates x
    issue(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h0);
    wait_done(1'b0);
    check("vecsat_x", longint'(x_out), 32'h7FFF_FFFF);
    check("vecsat_ovf", longint'(ovf), 1);
    check_tol("vecsat_z", sx(W, z_out), longint'($rtoi(0.25 * 3.14159265358979 * 1073741824.0)), 32'h10000);

    // handshake: starts during run and during done are dropped, inputs wiggle mid-run
    issue(1'b1, 32'h2000_0000, 32'h2000_0000, 32'h0);
    t0h = cyc; bcnt = busy ? 1 : 0; dcnt = 0;
    do begin
      @(negedge clk);
      k = cyc - t0h;
      if (busy) bcnt++;
      if (done) dcnt++;
      start = (k == 3) || (k == 16) || (k == 17);
      x_in = $urandom; y_in = $urandom;
    end while (k < 17);
    check("hs_busy_cycles", bcnt, N + 1);
    check("hs_done_pulses", dcnt, 1);
    issue(1'b0, 32'h4000_0000, 32'h0, 32'h0);
    wait_done(1'b0);

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      rm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        ra = $urandom; rb = $urandom;
        rc = $urandom_range(0, 32'h8000_0000) - 32'h4000_0000;
      end else begin
        rb = $urandom_range(0, 32'h4000_0000) - 32'h2000_0000;
        ra = rm ? $urandom_range(1, 32'h4000_0000) : $urandom_range(0, 32'h4000_0000) - 32'h2000_0000;
        rc = rm ? $urandom_range(0, 32'h2000_0000) - 32'h1000_0000
                : $urandom_range(0, 32'hD999_9998) - 32'h6CCC_CCCC;
      end
      issue(rm, ra, rb, rc);
      wait_done(1'b0);
    end

    // reset in the middle of an operation
    issue(1'b0, 32'h3000_0000, 32'h1000_0000, 32'h2000_0000);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_done", longint'(done), 0);
    check("mid_rst_ovf", longint'(ovf), 0);
    check("mid_rst_x", longint'(x_out), 0);
    check("mid_rst_y", longint'(y_out), 0);
    check("mid_rst_z", longint'(z_out), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("post_rst_no_done", dcnt, 0);
    issue(1'b1, 32'h2000_0000, 32'h2000_0000, 32'h0);
    wait_done(1'b0);
    check_tol("post_rst_vec_z", sx(W, z_out), longint'($rtoi(0.25 * 3.14159265358979 * 1073741824.0)), 32'h10000);

    // 16-bit, 8-iteration instance
    issue16(1'b0, 32'h4000, 32'h0, 32'h0);
    wait_done(1'b1);
    check_tol("w16_x", sx(W2, {16'h0, s_x_out}), longint'($rtoi(k16 * 16384.0)), 16);
    check_tol("w16_y", sx(W2, {16'h0, s_y_out}), 0, 1024);
    for (int r = 0; r < 12; r++) begin
      rm = 1'($urandom_range(0, 1));
      ra = rm ? $urandom_range(1, 32'h4000) : $urandom_range(0, 32'h4000) - 32'h2000;
      rb = $urandom_range(0, 32'h4000) - 32'h2000;
      rc = rm ? 32'h0 : $urandom_range(0, 32'hD998) - 32'h6CCC;
      issue16(rm, ra, rb, rc);
      wait_done(1'b1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", longint'(sb.size() + sb16.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
